rect_draw_engine: RTL and testbench

RECT_DRAW_ENGINE -- requirements
Module: rect_draw_engine

---
 rtl/rect_draw_engine.sv | 112 +++++++++++
 tb/tb_rect_draw_engine.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/rect_draw_engine.sv
// Rectangle fill engine: walks a BLK_W x BLK_H block one pixel per clock,
// column-major, clipping pixels that fall off the visible screen.
module rect_draw_engine #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int BLK_W    = 8,
  parameter int BLK_H    = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter logic [COLOUR_W-1:0] FLASH_COLOUR = '1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [X_W-1:0]      x_in,
  input  logic [Y_W-1:0]      y_in,
  input  logic [COLOUR_W-1:0] colour_in,
  input  logic                flash,
  output logic                busy,
  output logic                done,
  output logic                plot,
  output logic [X_W-1:0]      x_out,
  output logic [Y_W-1:0]      y_out,
  output logic [COLOUR_W-1:0] colour_out
);

  typedef enum logic [1:0] {IDLE, DRAW, DONE} state_e;

  localparam logic [X_W-1:0] COL_LAST = X_W'(BLK_W - 1);
  localparam logic [Y_W-1:0] ROW_LAST = Y_W'(BLK_H - 1);
  localparam logic [X_W:0]   SCR_W    = (X_W + 1)'(SCREEN_W);
  localparam logic [Y_W:0]   SCR_H    = (Y_W + 1)'(SCREEN_H);

  state_e              state_q, state_d;
  logic [X_W-1:0]      x0_q, x0_d, col_q, col_d;
  logic [Y_W-1:0]      y0_q, y0_d, row_q, row_d;
  logic [COLOUR_W-1:0] colour_q, colour_d;
  logic [X_W:0]        sum_x;
  logic [Y_W:0]        sum_y;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      x0_q     <= '0;
      y0_q     <= '0;
      col_q    <= '0;
      row_q    <= '0;
      colour_q <= COLOUR_W'(1);
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      col_q    <= col_d;
      row_q    <= row_d;
      colour_q <= colour_d;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    col_d    = col_q;
    row_d    = row_q;
    colour_d = colour_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          x0_d     = x_in;
          y0_d     = y_in;
          colour_d = colour_in;
          col_d    = '0;
          row_d    = '0;
          state_d  = DRAW;
        end
      end
      DRAW: begin
        // Row is the inner count; the column advances when a column finishes.
        if (row_q == ROW_LAST) begin
          row_d = '0;
          if (col_q == COL_LAST) begin
            col_d   = '0;
            state_d = DONE;
          end else begin
            col_d = col_q + X_W'(1);
          end
        end else begin
          row_d = row_q + Y_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One extra bit keeps the unwrapped sum so off-screen pixels clip, not wrap.
  assign sum_x = {1'b0, x0_q} + {1'b0, col_q};
  assign sum_y = {1'b0, y0_q} + {1'b0, row_q};

  assign busy       = (state_q == DRAW);
  assign done       = (state_q == DONE);
  assign plot       = busy && (sum_x < SCR_W) && (sum_y < SCR_H);
  assign x_out      = sum_x[X_W-1:0];
  assign y_out      = sum_y[Y_W-1:0];
  assign colour_out = flash ? FLASH_COLOUR : colour_q;

endmodule

// File: tb/tb_rect_draw_engine.sv
// Directed bench for rect_draw_engine: default 8x8 block plus a 1x1 instance.
module tb_rect_draw_engine;

  logic       clock = 1'b0;
  logic       reset, start, flash;
  logic [7:0] x_in;
  logic [6:0] y_in;
  logic [2:0] colour_in;
  logic       busy, done, plot;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour_out;

  logic       start1;
  logic [7:0] x1_in, x1_out;
  logic [6:0] y1_in, y1_out;
  logic [2:0] c1_in, c1_out;
  logic       busy1, done1, plot1;

  int n_total = 0;
  int n_pass  = 0;

  logic [7:0] obs_x    [64];
  logic [6:0] obs_y    [64];
  logic       obs_plot [64];

  always #5 clock = ~clock;

  rect_draw_engine u_dut (
    .clock(clock), .reset(reset), .start(start), .x_in(x_in), .y_in(y_in),
    .colour_in(colour_in), .flash(flash), .busy(busy), .done(done), .plot(plot),
    .x_out(x_out), .y_out(y_out), .colour_out(colour_out)
  );

  rect_draw_engine #(.BLK_W(1), .BLK_H(1)) u_one (
    .clock(clock), .reset(reset), .start(start1), .x_in(x1_in), .y_in(y1_in),
    .colour_in(c1_in), .flash(1'b0), .busy(busy1), .done(done1), .plot(plot1),
    .x_out(x1_out), .y_out(y1_out), .colour_out(c1_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Called at posedge+1; returns at posedge+1 of the first DRAW cycle.
  task automatic drive_start(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    start = 1'b1; x_in = x; y_in = y; colour_in = c;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // Checks 64 DRAW cycles then the done pulse. flash is high for cycles
  // fl_lo..fl_hi; a stray start with new coordinates is issued at cycle rs_k.
  task automatic draw_check(input string name, input logic [7:0] x0, input logic [6:0] y0,
                            input logic [2:0] c, input int fl_lo, input int fl_hi,
                            input int rs_k, output int nplot);
    logic [8:0]  ex;
    logic [7:0]  ey;
    logic        ep;
    logic [2:0]  ec;
    nplot = 0;
    for (int k = 0; k < 64; k++) begin
      flash = (k >= fl_lo) && (k <= fl_hi);
      start = (k == rs_k);
      if (k == rs_k) begin x_in = 8'd3; y_in = 7'd4; colour_in = 3'b001; end
      ex = {1'b0, x0} + 9'(k / 8);
      ey = {1'b0, y0} + 8'(k % 8);
      ep = (ex < 9'd160) && (ey < 8'd120);
      ec = flash ? 3'b111 : c;
      @(negedge clock);
      obs_x[k] = x_out; obs_y[k] = y_out; obs_plot[k] = plot;
      if (plot) nplot++;
      check($sformatf("%s_px%0d", name, k), {12'd0, busy, done, plot, x_out, y_out, colour_out},
            {12'd0, 1'b1, 1'b0, ep, ex[7:0], ey[6:0], ec});
      @(posedge clock); #1;
    end
    flash = 1'b0; start = 1'b0;
    @(negedge clock);
    check({name, "_done"}, {busy, done, plot}, 3'b010);
    @(posedge clock); #1;
    @(negedge clock);
    check({name, "_idle"}, {busy, done, plot}, 3'b000);
    @(posedge clock); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int np;
    int ndone;
    reset = 1'b1; start = 1'b0; flash = 1'b0;
    x_in = '0; y_in = '0; colour_in = '0;
    start1 = 1'b0; x1_in = '0; y1_in = '0; c1_in = '0;
    // Start is held high during reset to show reset wins.
    start = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0; start = 1'b0;

    // Reset state
    @(negedge clock);
    check("rst_ctrl", {busy, done, plot}, 3'b000);
    check("rst_xy", {x_out, y_out}, 15'd0);
    check("rst_colour", colour_out, 3'b001);
    check("rst_one_ctrl", {busy1, done1, plot1}, 3'b000);
    @(posedge clock); #1 flash = 1'b1;
    @(negedge clock);
    check("rst_flash_colour", colour_out, 3'b111);
    @(posedge clock); #1 flash = 1'b0;

    // Basic draw at (10,20), colour 100
    drive_start(8'd10, 7'd20, 3'b100);
    draw_check("basic", 8'd10, 7'd20, 3'b100, -1, -1, -1, np);
    check("basic_nplot", np, 64);
    check("basic_first", {obs_x[0], obs_y[0]}, {8'd10, 7'd20});
    check("basic_second", {obs_x[1], obs_y[1]}, {8'd10, 7'd21});
    check("basic_ninth", {obs_x[8], obs_y[8]}, {8'd11, 7'd20});
    check("basic_last", {obs_x[63], obs_y[63]}, {8'd17, 7'd27});

    // Clipping at the bottom-right corner
    drive_start(8'd156, 7'd116, 3'b101);
    draw_check("clip", 8'd156, 7'd116, 3'b101, -1, -1, -1, np);
    check("clip_nplot", np, 16);
    check("clip_corner_on", {obs_plot[3], obs_x[3], obs_y[3]}, {1'b1, 8'd156, 7'd119});
    check("clip_y_off", {obs_plot[4], obs_y[4]}, {1'b0, 7'd120});
    check("clip_x_nowrap", {obs_plot[32], obs_x[32]}, {1'b0, 8'd160});

    // Flash for three cycles mid-draw
    drive_start(8'd40, 7'd50, 3'b010);
    draw_check("flash", 8'd40, 7'd50, 3'b010, 20, 22, -1, np);
    check("flash_nplot", np, 64);

    // Second start during DRAW is ignored
    drive_start(8'd60, 7'd70, 3'b011);
    draw_check("restart", 8'd60, 7'd70, 3'b011, -1, -1, 10, np);
    check("restart_nplot", np, 64);

    // Reset at the 30th DRAW cycle aborts with no done pulse
    drive_start(8'd20, 7'd30, 3'b110);
    repeat (29) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check("abort_pre", {busy, x_out, y_out}, {1'b1, 8'd23, 7'd35});
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    check("abort_ctrl", {busy, done, plot}, 3'b000);
    check("abort_state", {x_out, y_out, colour_out}, {8'd0, 7'd0, 3'b001});
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (done || busy) ndone++;
    end
    check("abort_no_done", ndone, 0);
    @(posedge clock); #1;
    drive_start(8'd0, 7'd0, 3'b111);
    draw_check("after_abort", 8'd0, 7'd0, 3'b111, -1, -1, -1, np);
    check("after_abort_nplot", np, 64);

    // 1x1 block
    start1 = 1'b1; x1_in = 8'd0; y1_in = 7'd0; c1_in = 3'b110;
    @(posedge clock); #1 start1 = 1'b0;
    @(negedge clock);
    check("one_pixel", {busy1, done1, plot1, x1_out, y1_out, c1_out}, {3'b101, 8'd0, 7'd0, 3'b110});
    @(posedge clock); #1;
    @(negedge clock);
    check("one_done", {busy1, done1, plot1}, 3'b010);
    @(posedge clock); #1;
    @(negedge clock);
    check("one_idle", {busy1, done1, plot1}, 3'b000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
